// File: rtl/bin_enc_16x4_queue_pkg.sv
// Shared constants, state encoding and bit helpers for the 16-line binary codec blocks.
package bin_codec_pkg;

  localparam int N_LINES = 16;
  localparam int CODE_W  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  function automatic logic [4:0] popcount16(input logic [N_LINES-1:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < N_LINES; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/bin_enc_16x4_queue_prio.sv
// Rotating priority encoder: finds the first set bit at or after 'start', wrapping at 15.
module prio_enc_16x4
  import bin_codec_pkg::*;
(
  input  logic [N_LINES-1:0] vec,
  input  logic [CODE_W-1:0]  start,
  output logic [CODE_W-1:0]  code,
  output logic               found
);

  logic [2*N_LINES-1:0] dbl_s;
  logic [N_LINES-1:0]   rot_s;
  logic [CODE_W-1:0]    idx_s;

  // Rotate so 'start' lands at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    dbl_s = {vec, vec} >> start;
    rot_s = dbl_s[N_LINES-1:0];
    idx_s = {CODE_W{1'b0}};
    for (int i = N_LINES - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        idx_s = CODE_W'(i);
      end else begin
        idx_s = idx_s;
      end
    end
    found = |rot_s;
    code  = idx_s + start;
  end

endmodule

// File: rtl/bin_enc_16x4_queue.sv
// Sequential 16-to-4 encoder: collects request pulses into a pending set and
// serves them one binary code at a time over a valid/ready slot.
module bin_enc_16x4_queue
  import bin_codec_pkg::*;
#(
  parameter int RR_MODE = 0,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_LINES-1:0] req,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CODE_W-1:0]  out_code,
  output logic               any_pending,
  output logic [CNT_W-1:0]   coalesce_cnt
);

  localparam logic [CNT_W+4:0] CNT_MAX = (CNT_W+5)'({CNT_W{1'b1}});

  state_e             state_r, state_nxt_s;
  logic [N_LINES-1:0] pending_r;
  logic [CODE_W-1:0]  out_code_r, last_code_r;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [CODE_W-1:0]  start_s, sel_s;
  logic               found_s, accept_s, load_s;
  logic [N_LINES-1:0] load_mask_s, req_eff_s, merge_s;
  logic [CNT_W+4:0]   sum_s;

  prio_enc_16x4 u_prio (
    .vec   (pending_r),
    .start (start_s),
    .code  (sel_s),
    .found (found_s)
  );

  // Selection, load decision and saturating coalesce arithmetic.
  always_comb begin
    if (RR_MODE != 0) begin
      start_s = last_code_r + CODE_W'(1);
    end else begin
      start_s = {CODE_W{1'b0}};
    end
    accept_s    = (state_r == ST_OFFER) && out_ready;
    load_s      = ((state_r == ST_IDLE) || accept_s) && found_s;
    load_mask_s = load_s ? (N_LINES'(1) << sel_s) : {N_LINES{1'b0}};
    req_eff_s   = en ? req : {N_LINES{1'b0}};
    // A bit loaded this edge re-pends rather than merging.
    merge_s     = req_eff_s & pending_r & ~load_mask_s;
    sum_s       = {5'd0, cnt_r} + {{CNT_W{1'b0}}, popcount16(merge_s)};
    if (sum_s > CNT_MAX) begin
      cnt_nxt_s = {CNT_W{1'b1}};
    end else begin
      cnt_nxt_s = sum_s[CNT_W-1:0];
    end
  end

  // Slot FSM next state; flush always returns the slot to idle.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_nxt_s = load_s ? ST_OFFER : ST_IDLE;
        ST_OFFER: state_nxt_s = (accept_s && !found_s) ? ST_IDLE : ST_OFFER;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Slot FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pending set, offered code, round-robin pointer and coalesce counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r   <= {N_LINES{1'b0}};
      out_code_r  <= {CODE_W{1'b0}};
      last_code_r <= {CODE_W{1'b1}};
      cnt_r       <= {CNT_W{1'b0}};
    end else if (flush) begin
      pending_r   <= {N_LINES{1'b0}};
    end else begin
      pending_r <= (pending_r & ~load_mask_s) | req_eff_s;
      cnt_r     <= cnt_nxt_s;
      if (load_s) begin
        out_code_r  <= sel_s;
        last_code_r <= sel_s;
      end
    end
  end

  assign out_valid    = (state_r == ST_OFFER);
  assign out_code     = out_code_r;
  assign any_pending  = |pending_r;
  assign coalesce_cnt = cnt_r;

endmodule

// File: tb/tb_bin_enc_16x4_queue.sv
// Bench for bin_enc_16x4_queue: fixed-priority, round-robin and narrow-counter instances
// driven in parallel, checked against vector tables and a queue-level reference model.
module tb_bin_enc_16x4_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] req = 16'h0000;

  logic       v0, v1, v2, a0, a1, a2;
  logic [3:0] c0, c1, c2;
  logic [7:0] n0, n1;
  logic [1:0] n2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_enc_16x4_queue #(.RR_MODE(0), .CNT_W(8)) d_fix (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .flush(flush),
    .out_valid(v0), .out_ready(out_ready), .out_code(c0),
    .any_pending(a0), .coalesce_cnt(n0));

  bin_enc_16x4_queue #(.RR_MODE(1), .CNT_W(8)) d_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .flush(flush),
    .out_valid(v1), .out_ready(out_ready), .out_code(c1),
    .any_pending(a1), .coalesce_cnt(n1));

  bin_enc_16x4_queue #(.RR_MODE(0), .CNT_W(2)) d_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .flush(flush),
    .out_valid(v2), .out_ready(out_ready), .out_code(c2),
    .any_pending(a2), .coalesce_cnt(n2));

  // Reference model: a set of waiting indices plus one offered slot.
  typedef struct {
    logic [15:0] pend;
    bit          v;
    int          code;
    int          last;
    int          cnt;
  } mdl_t;

  mdl_t m[3];
  int   rrm[3]  = '{0, 1, 0};
  int   cmax[3] = '{255, 255, 3};

  function automatic void mreset();
    for (int i = 0; i < 3; i++) begin
      m[i].pend = 16'h0000; m[i].v = 1'b0; m[i].code = 0; m[i].last = 15; m[i].cnt = 0;
    end
  endfunction

  function automatic void mstep(int i, logic e, logic [15:0] r, logic f, logic rd);
    int          sel;
    int          idx;
    bit          acc;
    logic [15:0] p;
    sel = -1;
    p = m[i].pend;
    if (f) begin
      m[i].pend = 16'h0000;
      m[i].v = 1'b0;
      return;
    end
    acc = m[i].v && rd;
    if ((!m[i].v || acc) && p != 16'h0000) begin
      for (int k = 0; k < 16; k++) begin
        idx = (rrm[i] != 0) ? (m[i].last + 1 + k) % 16 : k;
        if (sel < 0 && p[idx]) sel = idx;
      end
    end
    if (e) begin
      for (int j = 0; j < 16; j++) begin
        if (r[j] && p[j] && j != sel && m[i].cnt < cmax[i]) m[i].cnt++;
      end
    end
    if (sel >= 0) begin
      p[sel] = 1'b0;
      m[i].v = 1'b1;
      m[i].code = sel;
      m[i].last = sel;
    end else if (acc) begin
      m[i].v = 1'b0;
    end
    if (e) p = p | r;
    m[i].pend = p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("fix_valid", 32'(v0), 32'(m[0].v));
    chk("fix_code",  32'(c0), 32'(m[0].code));
    chk("fix_any",   32'(a0), 32'(m[0].pend != 16'h0000));
    chk("fix_cnt",   32'(n0), 32'(m[0].cnt));
    chk("rr_valid",  32'(v1), 32'(m[1].v));
    chk("rr_code",   32'(c1), 32'(m[1].code));
    chk("rr_any",    32'(a1), 32'(m[1].pend != 16'h0000));
    chk("rr_cnt",    32'(n1), 32'(m[1].cnt));
    chk("sat_valid", 32'(v2), 32'(m[2].v));
    chk("sat_code",  32'(c2), 32'(m[2].code));
    chk("sat_any",   32'(a2), 32'(m[2].pend != 16'h0000));
    chk("sat_cnt",   32'(n2), 32'(m[2].cnt));
  endtask

  task automatic cyc(input logic e, input logic [15:0] r, input logic f, input logic rd);
    en = e; req = r; flush = f; out_ready = rd;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) mstep(i, e, r, f, rd);
    cmp_all();
  endtask

  task automatic do_reset();
    en = 1'b0; req = 16'h0000; flush = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    mreset();
    cmp_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        en;
    logic [15:0] req;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [3:0]  ec;
    logic        ea;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{1'b1, 16'h0020, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 8'd0};
    tbl[1]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 4'd5,  1'b0, 8'd0};
    tbl[2]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd5,  1'b0, 8'd0};
    tbl[3]  = '{1'b1, 16'h8001, 1'b0, 1'b0, 1'b0, 4'd5,  1'b1, 8'd0};
    tbl[4]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 8'd0};
    tbl[5]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 8'd0};
    tbl[6]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 8'd0};
    tbl[7]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0, 8'd0};
    tbl[8]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 8'd0};
    tbl[9]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1, 8'd0};
    tbl[10] = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 8'd1};
    tbl[11] = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 8'd3};
    tbl[12] = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 8'd5};
    tbl[13] = '{1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 8'd5};
    tbl[14] = '{1'b1, 16'h00F0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 8'd5};
    tbl[15] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd4,  1'b1, 8'd5};
    tbl[16] = '{1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 4'd4,  1'b0, 8'd5};
    tbl[17] = '{1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4'd4,  1'b0, 8'd5};
    tbl[18] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd4,  1'b0, 8'd5};

    // Directed vectors against the fixed-priority instance.
    do_reset();
    for (int t = 0; t < 19; t++) begin
      cyc(tbl[t].en, tbl[t].req, tbl[t].fl, tbl[t].rdy);
      chk($sformatf("tbl%0d_valid", t), 32'(v0), 32'(tbl[t].ev));
      chk($sformatf("tbl%0d_code", t),  32'(c0), 32'(tbl[t].ec));
      chk($sformatf("tbl%0d_any", t),   32'(a0), 32'(tbl[t].ea));
      chk($sformatf("tbl%0d_cnt", t),   32'(n0), 32'(tbl[t].ecnt));
    end
    chk("sat_stops_at_3", 32'(n2), 32'd3);

    // All sixteen lines at once drain in index order, one per cycle.
    do_reset();
    cyc(1'b1, 16'hFFFF, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 16'h0000, 1'b0, 1'b1);
      chk($sformatf("ffff_valid%0d", k), 32'(v0), 32'd1);
      chk($sformatf("ffff_code%0d", k),  32'(c0), 32'(k));
    end
    cyc(1'b1, 16'h0000, 1'b0, 1'b1);
    chk("ffff_drained", 32'(v0), 32'd0);
    cyc(1'b0, 16'hFFFF, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("en0_no_valid", 32'(v0), 32'd0);
    end

    // Round-robin re-pulse: 0, 4, 0, 4.
    do_reset();
    cyc(1'b1, 16'h0011, 1'b0, 1'b1);
    cyc(1'b1, 16'h0000, 1'b0, 1'b1);
    chk("rr_seq0", 32'(c1), 32'd0);
    cyc(1'b1, 16'h0011, 1'b0, 1'b1);
    chk("rr_seq1", 32'(c1), 32'd4);
    cyc(1'b1, 16'h0000, 1'b0, 1'b1);
    chk("rr_seq2", 32'(c1), 32'd0);
    cyc(1'b1, 16'h0000, 1'b0, 1'b1);
    chk("rr_seq3", 32'(c1), 32'd4);
    chk("rr_seq3_valid", 32'(v1), 32'd1);

    // Fixed priority re-serves index 0; round-robin moves on to 2.
    do_reset();
    cyc(1'b1, 16'h0005, 1'b0, 1'b1);
    cyc(1'b1, 16'h0001, 1'b0, 1'b1);
    cyc(1'b1, 16'h0000, 1'b0, 1'b1);
    chk("fix_repeat0", 32'(c0), 32'd0);
    chk("rr_skip_to2", 32'(c1), 32'd2);

    // Randomised traffic with occasional flush and asynchronous reset.
    do_reset();
    for (int t = 0; t < 600; t++) begin
      logic [15:0] r;
      int          sel;
      sel = int'($urandom_range(0, 5));
      if (sel == 0) r = 16'($urandom);
      else if (sel < 3) r = 16'h0001 << $urandom_range(0, 15);
      else r = 16'h0000;
      cyc(($urandom_range(0, 7) != 0), r, ($urandom_range(0, 40) == 0),
          ($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 120) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
